// File: rtl/tap_pkg.sv
// Shared definitions for the JTAG test access port: TAP states, opcodes,
// the IR capture pattern and the instruction-to-data-register decode.
package tap_pkg;

    typedef enum logic [3:0] {
        TAP_TLR    = 4'h0,
        TAP_RTI    = 4'h1,
        TAP_SEL_DR = 4'h2,
        TAP_CAP_DR = 4'h3,
        TAP_SH_DR  = 4'h4,
        TAP_EX1_DR = 4'h5,
        TAP_PAU_DR = 4'h6,
        TAP_EX2_DR = 4'h7,
        TAP_UPD_DR = 4'h8,
        TAP_SEL_IR = 4'h9,
        TAP_CAP_IR = 4'hA,
        TAP_SH_IR  = 4'hB,
        TAP_EX1_IR = 4'hC,
        TAP_PAU_IR = 4'hD,
        TAP_EX2_IR = 4'hE,
        TAP_UPD_IR = 4'hF
    } tap_state_e;

    typedef enum logic [1:0] {
        DR_BYPASS = 2'd0,
        DR_IDCODE = 2'd1,
        DR_BSR    = 2'd2
    } dr_sel_e;

    localparam logic [3:0] OP_EXTEST         = 4'b0000;
    localparam logic [3:0] OP_SAMPLE_PRELOAD = 4'b0001;
    localparam logic [3:0] OP_IDCODE         = 4'b0010;
    localparam logic [3:0] OP_BYPASS         = 4'b1111;

    // Loaded into the IR shift stage in Capture-IR; the trailing 01 lets a
    // host locate IR boundaries in a multi-device chain.
    localparam logic [3:0] IR_CAPTURE = 4'b0001;

    // Map an instruction to the data register it selects; anything
    // undefined falls back to the single-bit bypass register.
    function automatic dr_sel_e decode_dr(input logic [3:0] ir);
        dr_sel_e sel;
        case (ir)
            OP_EXTEST:         sel = DR_BSR;
            OP_SAMPLE_PRELOAD: sel = DR_BSR;
            OP_IDCODE:         sel = DR_IDCODE;
            default:           sel = DR_BYPASS;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/tap_fsm.sv
// 16-state TAP controller state machine. Holds only the state register and
// its next-state logic; the next state is exported so the parent can act
// on TLR entry in the same edge.
module tap_fsm
    import tap_pkg::*;
(
    input  logic       tck,
    input  logic       reset,
    input  logic       tms,
    output tap_state_e state_o,
    output tap_state_e next_o
);

    tap_state_e state_q;
    tap_state_e state_d;

    // State register; reset forces Test-Logic-Reset immediately.
    always_ff @(posedge tck or posedge reset) begin
        if (reset) begin
            state_q <= TAP_TLR;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode following the standard TAP diagram.
    always_comb begin
        state_d = state_q;
        case (state_q)
            TAP_TLR:    state_d = tms ? TAP_TLR    : TAP_RTI;
            TAP_RTI:    state_d = tms ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_DR: state_d = tms ? TAP_SEL_IR : TAP_CAP_DR;
            TAP_CAP_DR: state_d = tms ? TAP_EX1_DR : TAP_SH_DR;
            TAP_SH_DR:  state_d = tms ? TAP_EX1_DR : TAP_SH_DR;
            TAP_EX1_DR: state_d = tms ? TAP_UPD_DR : TAP_PAU_DR;
            TAP_PAU_DR: state_d = tms ? TAP_EX2_DR : TAP_PAU_DR;
            TAP_EX2_DR: state_d = tms ? TAP_UPD_DR : TAP_SH_DR;
            TAP_UPD_DR: state_d = tms ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_IR: state_d = tms ? TAP_TLR    : TAP_CAP_IR;
            TAP_CAP_IR: state_d = tms ? TAP_EX1_IR : TAP_SH_IR;
            TAP_SH_IR:  state_d = tms ? TAP_EX1_IR : TAP_SH_IR;
            TAP_EX1_IR: state_d = tms ? TAP_UPD_IR : TAP_PAU_IR;
            TAP_PAU_IR: state_d = tms ? TAP_EX2_IR : TAP_PAU_IR;
            TAP_EX2_IR: state_d = tms ? TAP_UPD_IR : TAP_SH_IR;
            TAP_UPD_IR: state_d = tms ? TAP_SEL_DR : TAP_RTI;
            default:    state_d = TAP_TLR;
        endcase
    end

    assign state_o = state_q;
    assign next_o  = state_d;

endmodule

// File: rtl/tap_controller.sv
// JTAG TAP controller: instruction register, bypass and IDCODE data
// registers, boundary-scan strobe decode and the TDO path multiplexer.
module tap_controller
    import tap_pkg::*;
#(
    parameter logic [31:0] IDCODE = 32'h1000_0001,
    parameter int          IR_LEN = 4
) (
    input  logic              tck,
    input  logic              reset,
    input  logic              tms,
    input  logic              tdi,
    output logic              tdo,
    output logic              tdo_en,
    input  logic              bsr_tdo,
    output logic              bsr_clk_dr,
    output logic              bsr_shift_dr,
    output logic              bsr_update_dr,
    output logic              bsr_mode,
    output logic              bsr_enable_in,
    output logic              bsr_enable_out,
    output logic [IR_LEN-1:0] ir_out
);

    tap_state_e        state_s;
    tap_state_e        next_s;
    dr_sel_e           dr_sel_s;
    logic              bsr_sel_s;

    logic [IR_LEN-1:0] ir_q,       ir_d;
    logic [IR_LEN-1:0] ir_shift_q, ir_shift_d;
    logic              bypass_q,   bypass_d;
    logic [31:0]       idcode_q,   idcode_d;

    tap_fsm u_fsm (
        .tck     (tck),
        .reset   (reset),
        .tms     (tms),
        .state_o (state_s),
        .next_o  (next_s)
    );

    assign dr_sel_s  = decode_dr(ir_q);
    assign bsr_sel_s = (dr_sel_s == DR_BSR);

    // All controller registers; reset discards any partial scan contents.
    always_ff @(posedge tck or posedge reset) begin
        if (reset) begin
            ir_q       <= OP_IDCODE;
            ir_shift_q <= {IR_LEN{1'b0}};
            bypass_q   <= 1'b0;
            idcode_q   <= IDCODE;
        end else begin
            ir_q       <= ir_d;
            ir_shift_q <= ir_shift_d;
            bypass_q   <= bypass_d;
            idcode_q   <= idcode_d;
        end
    end

    // IR shift stage: capture fixed pattern, then shift LSB-first from TDI.
    always_comb begin
        ir_shift_d = ir_shift_q;
        case (state_s)
            TAP_CAP_IR: ir_shift_d = IR_CAPTURE;
            TAP_SH_IR:  ir_shift_d = {tdi, ir_shift_q[IR_LEN-1:1]};
            default:    ir_shift_d = ir_shift_q;
        endcase
    end

    // Active IR: forced to IDCODE on the edge entering TLR, else latched
    // from the shift stage on the edge leaving Update-IR.
    always_comb begin
        ir_d = ir_q;
        if (next_s == TAP_TLR) begin
            ir_d = OP_IDCODE;
        end else if (state_s == TAP_UPD_IR) begin
            ir_d = ir_shift_q;
        end else begin
            ir_d = ir_q;
        end
    end

    // Bypass bit: cleared on capture, follows TDI while shifting.
    always_comb begin
        bypass_d = bypass_q;
        if (dr_sel_s == DR_BYPASS) begin
            case (state_s)
                TAP_CAP_DR: bypass_d = 1'b0;
                TAP_SH_DR:  bypass_d = tdi;
                default:    bypass_d = bypass_q;
            endcase
        end else begin
            bypass_d = bypass_q;
        end
    end

    // IDCODE register: reloads the device ID on capture, shifts LSB-first.
    always_comb begin
        idcode_d = idcode_q;
        if (dr_sel_s == DR_IDCODE) begin
            case (state_s)
                TAP_CAP_DR: idcode_d = IDCODE;
                TAP_SH_DR:  idcode_d = {tdi, idcode_q[31:1]};
                default:    idcode_d = idcode_q;
            endcase
        end else begin
            idcode_d = idcode_q;
        end
    end

    // Boundary-scan strobes, Moore-decoded and gated by BSR selection.
    always_comb begin
        bsr_clk_dr    = 1'b0;
        bsr_shift_dr  = 1'b0;
        bsr_update_dr = 1'b0;
        if (bsr_sel_s) begin
            case (state_s)
                TAP_CAP_DR: bsr_clk_dr = 1'b1;
                TAP_SH_DR: begin
                    bsr_clk_dr   = 1'b1;
                    bsr_shift_dr = 1'b1;
                end
                TAP_UPD_DR: bsr_update_dr = 1'b1;
                default: begin
                    bsr_clk_dr    = 1'b0;
                    bsr_shift_dr  = 1'b0;
                    bsr_update_dr = 1'b0;
                end
            endcase
        end else begin
            bsr_clk_dr    = 1'b0;
            bsr_shift_dr  = 1'b0;
            bsr_update_dr = 1'b0;
        end
    end

    // BSR mode/enable controls come straight from the active instruction.
    always_comb begin
        bsr_mode       = (ir_q == OP_EXTEST);
        bsr_enable_out = (ir_q == OP_EXTEST);
        bsr_enable_in  = (ir_q == OP_EXTEST) || (ir_q == OP_SAMPLE_PRELOAD);
    end

    // TDO path select: LSB of whichever register is being shifted.
    always_comb begin
        tdo    = 1'b0;
        tdo_en = (state_s == TAP_SH_DR) || (state_s == TAP_SH_IR);
        case (state_s)
            TAP_SH_IR: tdo = ir_shift_q[0];
            TAP_SH_DR: begin
                case (dr_sel_s)
                    DR_BSR:    tdo = bsr_tdo;
                    DR_IDCODE: tdo = idcode_q[0];
                    default:   tdo = bypass_q;
                endcase
            end
            default: tdo = 1'b0;
        endcase
    end

    assign ir_out = ir_q;

endmodule

// File: tb/tb_tap_controller.sv
// Self-checking bench for tap_controller: directed scans plus a randomized
// TMS/TDI walk, all checked every cycle against a table-driven model.
module tb_tap_controller;

    localparam logic [31:0] IDC = 32'h1000_0001;

    logic       tck = 1'b0;
    logic       reset, tms, tdi, bsr_tdo;
    logic       tdo, tdo_en, bsr_clk_dr, bsr_shift_dr, bsr_update_dr;
    logic       bsr_mode, bsr_enable_in, bsr_enable_out;
    logic [3:0] ir_out;

    int n_checks = 0;
    int n_fail   = 0;
    logic last_tdo;

    tap_controller #(.IDCODE(IDC), .IR_LEN(4)) dut (
        .tck(tck), .reset(reset), .tms(tms), .tdi(tdi), .tdo(tdo),
        .tdo_en(tdo_en), .bsr_tdo(bsr_tdo), .bsr_clk_dr(bsr_clk_dr),
        .bsr_shift_dr(bsr_shift_dr), .bsr_update_dr(bsr_update_dr),
        .bsr_mode(bsr_mode), .bsr_enable_in(bsr_enable_in),
        .bsr_enable_out(bsr_enable_out), .ir_out(ir_out)
    );

    always #5 tck = ~tck;

    // Reference model: state numbers and the 1149.1 diagram as tables.
    localparam int S_TLR=0,  S_RTI=1,  S_SELDR=2,  S_CAPDR=3,  S_SHDR=4,  S_EX1DR=5,
                   S_PAUDR=6, S_EX2DR=7, S_UPDDR=8, S_SELIR=9, S_CAPIR=10, S_SHIR=11,
                   S_EX1IR=12, S_PAUIR=13, S_EX2IR=14, S_UPDIR=15;
    int ns0 [16] = '{S_RTI, S_RTI, S_CAPDR, S_SHDR, S_SHDR, S_PAUDR, S_PAUDR, S_SHDR,
                     S_RTI, S_CAPIR, S_SHIR, S_SHIR, S_PAUIR, S_PAUIR, S_SHIR, S_RTI};
    int ns1 [16] = '{S_TLR, S_SELDR, S_SELIR, S_EX1DR, S_EX1DR, S_UPDDR, S_EX2DR, S_UPDDR,
                     S_SELDR, S_TLR, S_EX1IR, S_EX1IR, S_UPDIR, S_EX2IR, S_UPDIR, S_SELDR};

    int          m_st;
    logic [3:0]  m_ir, m_irsh;
    logic        m_byp;
    logic [31:0] m_idc;

    // 0 = bypass, 1 = IDCODE, 2 = boundary scan
    function automatic int dr_of(input logic [3:0] ir);
        if (ir == 4'd0 || ir == 4'd1) return 2;
        if (ir == 4'd2) return 1;
        return 0;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = S_TLR; m_ir = 4'b0010; m_irsh = 4'b0000; m_byp = 1'b0; m_idc = IDC;
    endtask

    task automatic model_step(input logic t, input logic d);
        int old = m_st;
        int sel = dr_of(m_ir);
        m_st = t ? ns1[old] : ns0[old];
        if (old == S_UPDIR) m_ir = m_irsh;
        if (m_st == S_TLR)  m_ir = 4'b0010;
        if (old == S_CAPIR)      m_irsh = 4'b0001;
        else if (old == S_SHIR)  m_irsh = {d, m_irsh[3:1]};
        if (old == S_CAPDR) begin
            if (sel == 1) m_idc = IDC;
            if (sel == 0) m_byp = 1'b0;
        end else if (old == S_SHDR) begin
            if (sel == 1) m_idc = {d, m_idc[31:1]};
            if (sel == 0) m_byp = d;
        end
    endtask

    task automatic check_outputs();
        int   sel = dr_of(m_ir);
        logic bsr = (sel == 2);
        logic e_tdo = 1'b0;
        if (m_st == S_SHIR) e_tdo = m_irsh[0];
        else if (m_st == S_SHDR) e_tdo = (sel == 2) ? bsr_tdo : (sel == 1) ? m_idc[0] : m_byp;
        check_eq("tdo",       32'(tdo),       32'(e_tdo));
        check_eq("tdo_en",    32'(tdo_en),    32'(m_st == S_SHDR || m_st == S_SHIR));
        check_eq("clk_dr",    32'(bsr_clk_dr),    32'(bsr && (m_st == S_CAPDR || m_st == S_SHDR)));
        check_eq("shift_dr",  32'(bsr_shift_dr),  32'(bsr && m_st == S_SHDR));
        check_eq("update_dr", 32'(bsr_update_dr), 32'(bsr && m_st == S_UPDDR));
        check_eq("mode",      32'(bsr_mode),       32'(m_ir == 4'd0));
        check_eq("en_out",    32'(bsr_enable_out), 32'(m_ir == 4'd0));
        check_eq("en_in",     32'(bsr_enable_in),  32'(m_ir == 4'd0 || m_ir == 4'd1));
        check_eq("ir_out",    32'(ir_out),         32'(m_ir));
    endtask

    // One TCK cycle: drive while low, model on the edge, check 1 ns later.
    task automatic clk_step(input logic t, input logic d);
        tms = t; tdi = d; bsr_tdo = 1'($urandom_range(0, 1));
        @(posedge tck);
        if (!reset) model_step(t, d);
        #1;
        check_outputs();
        last_tdo = tdo;
        @(negedge tck);
    endtask

    task automatic reset_pulse();
        #2 reset = 1'b1;
        #1 model_reset();
        check_outputs();
        @(posedge tck); #1;
        check_outputs();
        @(negedge tck);
        reset = 1'b0;
    endtask

    task automatic goto_tlr();
        for (int i = 0; i < 5; i++) clk_step(1'b1, 1'($urandom_range(0, 1)));
    endtask

    // From TLR or RTI: load an instruction and return to RTI.
    task automatic load_ir(input logic [3:0] op);
        logic [3:0] cap;
        clk_step(1'b0, 1'b0);
        clk_step(1'b1, 1'b0);
        clk_step(1'b1, 1'b0);
        clk_step(1'b0, 1'b0);
        clk_step(1'b0, 1'b0);
        cap[0] = last_tdo;
        for (int i = 0; i < 4; i++) begin
            clk_step(i == 3, op[i]);
            if (i < 3) cap[i+1] = last_tdo;
        end
        check_eq("ir_capture", 32'(cap), 32'(4'b0001));
        clk_step(1'b1, 1'b0);
        clk_step(1'b0, 1'b0);
        check_eq("ir_loaded", 32'(ir_out), 32'(op));
    endtask

    logic [7:0] path_bits [16] = '{8'b111, 8'b0, 8'b1, 8'b01, 8'b001, 8'b101, 8'b0101, 8'b10101,
                                   8'b1101, 8'b11, 8'b011, 8'b0011, 8'b1011, 8'b01011, 8'b101011, 8'b11011};
    int         path_len  [16] = '{3, 0, 1, 2, 3, 3, 4, 5, 4, 2, 3, 4, 4, 5, 6, 5};

    initial begin
        logic [31:0] idseq;
        logic [4:0]  bseq;
        int c_clk, c_sh, c_up;

        reset = 1'b1; tms = 1'b1; tdi = 1'b0; bsr_tdo = 1'b0;
        model_reset();
        #2;
        check_outputs();
        check_eq("reset_ir", 32'(ir_out), 32'(4'b0010));
        @(negedge tck); @(negedge tck);
        reset = 1'b0;

        // IDCODE scan straight out of reset
        clk_step(1'b0, 1'b0); clk_step(1'b1, 1'b0); clk_step(1'b0, 1'b0); clk_step(1'b0, 1'b0);
        idseq[0] = last_tdo;
        for (int i = 1; i < 32; i++) begin
            clk_step(1'b0, 1'b0);
            idseq[i] = last_tdo;
        end
        check_eq("idcode_seq", idseq, IDC);
        clk_step(1'b1, 1'b0); clk_step(1'b1, 1'b0); clk_step(1'b0, 1'b0);

        // BYPASS: 1,0,1,1 in -> 0,1,0,1,1 out
        load_ir(4'b1111);
        clk_step(1'b1, 1'b0); clk_step(1'b0, 1'b0); clk_step(1'b0, 1'b0);
        bseq = {4'b0000, last_tdo};
        clk_step(1'b0, 1'b1); bseq = {bseq[3:0], last_tdo};
        clk_step(1'b0, 1'b0); bseq = {bseq[3:0], last_tdo};
        clk_step(1'b0, 1'b1); bseq = {bseq[3:0], last_tdo};
        clk_step(1'b0, 1'b1); bseq = {bseq[3:0], last_tdo};
        check_eq("bypass_seq", 32'(bseq), 32'(5'b01011));
        clk_step(1'b1, 1'b0); clk_step(1'b1, 1'b0); clk_step(1'b0, 1'b0);

        // EXTEST controls and a 4-bit BSR scan
        load_ir(4'b0000);
        check_eq("extest_mode",   32'(bsr_mode),       32'd1);
        check_eq("extest_en_out", 32'(bsr_enable_out), 32'd1);
        check_eq("extest_en_in",  32'(bsr_enable_in),  32'd1);
        c_clk = 0; c_sh = 0; c_up = 0;
        foreach (path_bits[k]) begin end
        for (int i = 0; i < 9; i++) begin
            logic [8:0] seq = 9'b011000001;
            clk_step(seq[i], 1'($urandom_range(0, 1)));
            c_clk += int'(bsr_clk_dr); c_sh += int'(bsr_shift_dr); c_up += int'(bsr_update_dr);
        end
        check_eq("clk_dr_cycles",    32'(c_clk), 32'd5);
        check_eq("shift_dr_cycles",  32'(c_sh),  32'd4);
        check_eq("update_dr_cycles", 32'(c_up),  32'd1);

        // Five TMS=1 cycles reach TLR from every state
        for (int s = 0; s < 16; s++) begin
            load_ir(4'b1111);
            for (int b = 0; b < path_len[s]; b++) clk_step(path_bits[s][b], 1'($urandom_range(0, 1)));
            goto_tlr();
            check_eq("tlr_ir", 32'(ir_out), 32'(4'b0010));
            check_eq("tlr_tdo_en", 32'(tdo_en), 32'd0);
        end

        // Reset during the 2nd bit of an IR shift of 0000
        load_ir(4'b0000);
        clk_step(1'b1, 1'b0); clk_step(1'b1, 1'b0); clk_step(1'b0, 1'b0); clk_step(1'b0, 1'b0);
        clk_step(1'b0, 1'b0);
        tms = 1'b0; tdi = 1'b0;
        reset_pulse();
        check_eq("rst_ir",   32'(ir_out), 32'(4'b0010));
        check_eq("rst_bsr",  32'({bsr_clk_dr, bsr_shift_dr, bsr_update_dr, bsr_mode,
                                  bsr_enable_in, bsr_enable_out}), 32'd0);
        check_eq("rst_tdo_en", 32'(tdo_en), 32'd0);

        // Randomized walk with occasional asynchronous resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) reset_pulse();
            else clk_step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
